uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter in the uart_top datapath between N byte-stream requesters (e.g. a debug console, a status reporter and a test-pattern source).
- Grants one requester at a time, round-robin, and holds the grant for a whole packet (until a byte marked last).
- Buffers one byte and drives the transmitter's request/acknowledge handshake.
- Forcibly releases a stalled packet after a timeout so a requester that stops mid-packet cannot starve the others.

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_pick.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit-side arbiters.
package uart_pkg;

  localparam int BYTE_W  = 8;
  localparam int GRANT_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index scanning upward from
// last_ptr+1, wrapping modulo N.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]       valid,
  input  logic [GRANT_W-1:0] last_ptr,
  output logic               any,
  output logic [GRANT_W-1:0] index
);

  localparam int SLOTS = 1 << GRANT_W;

  logic [SLOTS-1:0]   valid_ext;
  logic [GRANT_W-1:0] cand_idx [N];
  logic [N-1:0]       cand_valid;

  // Padding to a power-of-two width lets any GRANT_W-bit index address it.
  assign valid_ext = SLOTS'(valid);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [GRANT_W:0] sum;
      assign sum = {1'b0, last_ptr} + (GRANT_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (GRANT_W+1)'(N)) ? GRANT_W'(sum - (GRANT_W+1)'(N))
                                                     : sum[GRANT_W-1:0];
      assign cand_valid[gi] = valid_ext[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        any   = 1'b1;
        index = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter in front of a single UART transmitter,
// with a one-byte holding register and a mid-packet stall timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_req,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_ack,
  output logic                    grant_valid,
  output logic [GRANT_W-1:0]      grant_id,
  output logic                    abort_pulse
);

  localparam int SLOTS   = 1 << GRANT_W;
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  // The abort fires on the edge where the timer would reach TIMEOUT_CYCLES-1.
  localparam logic [TIMER_W-1:0] TIMER_ABORT = TIMER_W'(TIMEOUT_CYCLES - 2);

  arb_state_t         state_reg, state_next;
  logic [GRANT_W-1:0] grant_id_reg, grant_id_next;
  logic [GRANT_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic               hold_full_reg, hold_full_next;
  logic               held_last_reg, held_last_next;
  logic [BYTE_W-1:0]  tx_data_reg, tx_data_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               abort_reg, abort_next;

  logic [SLOTS-1:0]   valid_ext;
  logic [SLOTS-1:0]   last_ext;
  logic [BYTE_W-1:0]  data_arr [SLOTS];
  logic               cur_valid;
  logic               cur_last;
  logic [BYTE_W-1:0]  cur_data;
  logic               pick_any;
  logic [GRANT_W-1:0] pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < N_REQ) begin : g_used
        assign valid_ext[gi] = req_valid[gi];
        assign last_ext[gi]  = req_last[gi];
        assign data_arr[gi]  = req_data[BYTE_W*gi +: BYTE_W];
      end else begin : g_pad
        assign valid_ext[gi] = 1'b0;
        assign last_ext[gi]  = 1'b0;
        assign data_arr[gi]  = '0;
      end
    end

    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == LOCKED) && !hold_full_reg &&
                             (grant_id_reg == GRANT_W'(gi));
    end
  endgenerate

  assign cur_valid = valid_ext[grant_id_reg];
  assign cur_last  = last_ext[grant_id_reg];
  assign cur_data  = data_arr[grant_id_reg];

  rr_pick #(.N(N_REQ)) u_pick (
    .valid    (req_valid),
    .last_ptr (rr_ptr_reg),
    .any      (pick_any),
    .index    (pick_idx)
  );

  always_comb begin
    state_next     = state_reg;
    grant_id_next  = grant_id_reg;
    rr_ptr_next    = rr_ptr_reg;
    hold_full_next = hold_full_reg;
    held_last_next = held_last_reg;
    tx_data_next   = tx_data_reg;
    timer_next     = timer_reg;
    abort_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (pick_any) begin
          state_next    = LOCKED;
          grant_id_next = pick_idx;
        end
      end
      LOCKED: begin
        if (hold_full_reg) begin
          // Timer frozen: a slow transmitter must never trigger an abort.
          if (tx_ack) begin
            hold_full_next = 1'b0;
            if (held_last_reg) begin
              state_next  = IDLE;
              rr_ptr_next = grant_id_reg;
            end
          end
        end else if (cur_valid) begin
          hold_full_next = 1'b1;
          tx_data_next   = cur_data;
          held_last_next = cur_last;
          timer_next     = '0;
        end else if (timer_reg == TIMER_ABORT) begin
          state_next  = IDLE;
          rr_ptr_next = grant_id_reg;
          abort_next  = 1'b1;
          timer_next  = timer_reg + TIMER_W'(1);
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_id_reg  <= '0;
      rr_ptr_reg    <= GRANT_W'(N_REQ - 1);
      hold_full_reg <= 1'b0;
      held_last_reg <= 1'b0;
      tx_data_reg   <= '0;
      timer_reg     <= '0;
      abort_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_id_reg  <= grant_id_next;
      rr_ptr_reg    <= rr_ptr_next;
      hold_full_reg <= hold_full_next;
      held_last_reg <= held_last_next;
      tx_data_reg   <= tx_data_next;
      timer_reg     <= timer_next;
      abort_reg     <= abort_next;
    end
  end

  assign tx_req      = hold_full_reg;
  assign tx_data     = tx_data_reg;
  assign grant_valid = (state_reg == LOCKED);
  assign grant_id    = grant_id_reg;
  assign abort_pulse = abort_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: tests push expected (grant_id, byte) pairs, a monitor pops
// and compares on every transmitter handshake.
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 3;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [N_REQ-1:0]  req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]  req_last;
  logic [N_REQ-1:0]  req_ready;
  logic              tx_req;
  logic [7:0]        tx_data;
  logic              tx_ack;
  logic              grant_valid;
  logic [2:0]        grant_id;
  logic              abort_pulse;

  uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_ack      (tx_ack),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .abort_pulse (abort_pulse)
  );

  initial forever #5 clock = ~clock;

  typedef struct packed { logic [1:0] id; logic last; logic [7:0] data; } ent_t;
  typedef struct packed { logic [2:0] id; logic [7:0] data; } exp_t;

  ent_t in_q[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   abort_count = 0;
  int   ack_delay = 3;
  logic edge_rst = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  function automatic int front_idx(input int r);
    for (int i = 0; i < in_q.size(); i++)
      if (int'(in_q[i].id) == r) return i;
    return -1;
  endfunction

  task automatic load(input int r, input logic [7:0] d, input logic l);
    in_q.push_back({2'(r), l, d});
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    exp_q.push_back({3'(r), d});
  endtask

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  task automatic wait_exp(input int remaining, input int max_cyc, input string name);
    int n = 0;
    while (exp_q.size() > remaining && n < max_cyc) begin
      step();
      n++;
    end
    check(name, exp_q.size(), remaining);
  endtask

  // Requester model: present the head of each requester's queue, pop on handshake.
  initial begin
    logic [N_REQ-1:0] fire;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clock);
      fire = req_valid & req_ready;
      @(posedge clock);
      if (!rst_n) fire = '0;
      #1;
      for (int r = 0; r < N_REQ; r++) begin
        int idx;
        if (fire[r]) begin
          idx = front_idx(r);
          if (idx >= 0) in_q.delete(idx);
        end
        idx = front_idx(r);
        req_valid[r]         = (idx >= 0);
        req_data[8*r +: 8]   = (idx >= 0) ? in_q[idx].data : 8'h00;
        req_last[r]          = (idx >= 0) ? in_q[idx].last : 1'b0;
      end
    end
  end

  // Transmitter model: one-cycle ack ack_delay cycles after tx_req rises.
  initial begin
    int wait_cnt = 0;
    tx_ack = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (tx_ack) begin
        tx_ack = 1'b0;
        wait_cnt = 0;
      end else if (tx_req) begin
        if (wait_cnt >= ack_delay) tx_ack = 1'b1;
        else wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial forever begin
    @(posedge clock);
    edge_rst = rst_n;
  end

  // Monitor: scoreboard on handshakes, hold-stability of the pending byte.
  initial begin
    exp_t e;
    logic prev_req = 1'b0, prev_ack = 1'b0;
    logic [7:0] prev_data = 8'h00;
    forever begin
      @(negedge clock);
      #1;
      if (tx_req && tx_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("grant_id", 32'(grant_id), 32'(e.id));
        end
      end
      if (prev_req && !prev_ack && edge_rst) begin
        check("tx_req_hold", 32'(tx_req), 1);
        check("tx_data_hold", 32'(tx_data), 32'(prev_data));
      end
      if (abort_pulse) abort_count++;
      prev_req  = tx_req;
      prev_ack  = tx_ack;
      prev_data = tx_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_n = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_tx_req", 32'(tx_req), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_abort", 32'(abort_pulse), 0);
    rst_n = 1'b1;
    step();

    // Single requester, with grant/capture latency
    load(1, 8'h48, 1'b0); load(1, 8'h69, 1'b1);
    expect_byte(1, 8'h48); expect_byte(1, 8'h69);
    step();
    check("t1_gv_t0", 32'(grant_valid), 0);
    step();
    check("t1_gv_t1", 32'(grant_valid), 1);
    check("t1_ready_t1", 32'(req_ready), 32'h2);
    step();
    check("t1_txreq_t2", 32'(tx_req), 1);
    check("t1_txdata_t2", 32'(tx_data), 32'h48);
    wait_exp(0, 60, "t1_drain");
    check("t1_gv_ack_cycle", 32'(grant_valid), 1);
    step();
    check("t1_gv_after_ack", 32'(grant_valid), 0);
    check("t1_no_abort", abort_count, 0);

    // Round-robin from reset, twice
    rst_n = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      load(r, 8'(16*r + 1), 1'b0); load(r, 8'(16*r + 2), 1'b1);
      expect_byte(r, 8'(16*r + 1)); expect_byte(r, 8'(16*r + 2));
    end
    repeat (2) step();
    rst_n = 1'b1;
    wait_exp(0, 200, "t2_drain");
    step();
    for (int r = 0; r < N_REQ; r++) begin
      load(r, 8'(16*r + 3), 1'b0); load(r, 8'(16*r + 4), 1'b1);
      expect_byte(r, 8'(16*r + 3)); expect_byte(r, 8'(16*r + 4));
    end
    wait_exp(0, 200, "t2b_drain");
    step();

    // No interleave: requester 2 arrives mid-packet of requester 0
    load(0, 8'h30, 1'b0); load(0, 8'h31, 1'b0); load(0, 8'h32, 1'b1);
    expect_byte(0, 8'h30); expect_byte(0, 8'h31); expect_byte(0, 8'h32);
    wait_exp(2, 60, "t3_first");
    load(2, 8'h40, 1'b0); load(2, 8'h41, 1'b1);
    expect_byte(2, 8'h40); expect_byte(2, 8'h41);
    wait_exp(0, 200, "t3_drain");
    step();

    // Timeout: requester 0 stalls after one byte, requester 1 waits
    base = abort_count;
    load(0, 8'hAA, 1'b0);
    load(1, 8'h50, 1'b0); load(1, 8'h51, 1'b1);
    expect_byte(0, 8'hAA); expect_byte(1, 8'h50); expect_byte(1, 8'h51);
    wait_exp(2, 60, "t4_aa_acked");
    n = 0;
    while (!abort_pulse && n < 40) begin
      step();
      n++;
    end
    check("t4_abort_delay", n, TIMEOUT);
    check("t4_gv_at_abort", 32'(grant_valid), 0);
    step();
    check("t4_abort_width", 32'(abort_pulse), 0);
    wait_exp(0, 200, "t4_drain");
    check("t4_abort_count", abort_count - base, 1);
    step();

    // Slow transmitter: no abort, pending byte held steady
    ack_delay = 100;
    base = abort_count;
    load(2, 8'h5A, 1'b0); load(2, 8'h5B, 1'b1);
    expect_byte(2, 8'h5A); expect_byte(2, 8'h5B);
    wait_exp(0, 400, "t5_drain");
    check("t5_no_abort", abort_count - base, 0);
    step();

    // Reset while a byte is held
    load(1, 8'h77, 1'b0); load(1, 8'h78, 1'b1);
    n = 0;
    while (!tx_req && n < 20) begin
      step();
      n++;
    end
    check("t6_txreq_up", 32'(tx_req), 1);
    load(0, 8'h10, 1'b1);
    expect_byte(0, 8'h10); expect_byte(1, 8'h78);
    rst_n = 1'b0;
    step();
    check("t6_txreq_rst", 32'(tx_req), 0);
    check("t6_gv_rst", 32'(grant_valid), 0);
    check("t6_ready_rst", 32'(req_ready), 0);
    check("t6_txdata_rst", 32'(tx_data), 0);
    rst_n = 1'b1;
    ack_delay = 3;
    wait_exp(0, 100, "t6_drain");
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
